// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (LSB first, idle high) fed through a one-entry holding register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int unsigned CLK_TICKSPER_BIT = 87
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_active,
    output logic       o_tx_serial,
    output logic       o_tx_done
);

    localparam int unsigned TW = (CLK_TICKSPER_BIT > 1) ? $clog2(CLK_TICKSPER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_TICKSPER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3
    } state_t;
`endif

    state_t          state, state_d;
    logic [TW-1:0]   cnt, cnt_d;
    logic [2:0]      idx, idx_d;
    logic [7:0]      shift, shift_d;
    logic            hold_valid, hold_valid_d;
    logic [7:0]      hold_byte, hold_byte_d;
    logic            ready_d, active_d, serial_d, done_d;
    logic            bit_end, take;

    // Next-state, holding register and registered-output values
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        idx_d        = idx;
        shift_d      = shift;
        hold_valid_d = hold_valid;
        hold_byte_d  = hold_byte;
        take         = 1'b0;
        done_d       = 1'b0;
        serial_d     = 1'b1;
        bit_end      = (cnt == TICK_LAST);

        case (state)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (hold_valid) begin
                    take    = 1'b1;
                    shift_d = hold_byte;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt + TW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    idx_d = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt + TW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt + TW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d  = '0;
                    idx_d  = '0;
                    done_d = 1'b1;
                    if (hold_valid) begin
                        take    = 1'b1;
                        shift_d = hold_byte;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[idx_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = ^shift_d;
`endif
            default: serial_d = 1'b1;
        endcase

        if (take) begin
            hold_valid_d = 1'b0;
        end
        if (i_tx_dv && o_tx_ready) begin
            hold_valid_d = 1'b1;
            hold_byte_d  = i_tx_byte;
        end

        // Ready stays low one extra cycle after a take so a byte can never land on a full register
        ready_d  = !(hold_valid_d || hold_valid);
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            hold_valid  <= 1'b0;
            hold_byte   <= '0;
            o_tx_ready  <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_serial <= 1'b1;
            o_tx_done   <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx_d;
            shift       <= shift_d;
            hold_valid  <= hold_valid_d;
            hold_byte   <= hold_byte_d;
            o_tx_ready  <= ready_d;
            o_tx_active <= active_d;
            o_tx_serial <= serial_d;
            o_tx_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: queue-based line model checked every cycle, plus literal frame/timing expectations.
module tb_uart_tx;

    localparam int TPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL   = FB * TPB;
    localparam int LOGN = 4096;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_tx_dv;
    logic [7:0] i_tx_byte;
    logic       o_tx_ready, o_tx_active, o_tx_serial, o_tx_done;

    uart_tx #(.CLK_TICKSPER_BIT(TPB)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tx_dv     (i_tx_dv),
        .i_tx_byte   (i_tx_byte),
        .o_tx_ready  (o_tx_ready),
        .o_tx_active (o_tx_active),
        .o_tx_serial (o_tx_serial),
        .o_tx_done   (o_tx_done)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic log_ser  [0:LOGN-1];
    logic log_done [0:LOGN-1];
    logic log_rdy  [0:LOGN-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: expected line as a queue of per-cycle bits, fed from a modelled holding register
    logic q[$];
    logic m_hold_v = 1'b0;
    logic [7:0] m_hold_b;
    logic model_on = 1'b0;
    logic e_serial, e_ready, e_active, e_done;

    function automatic void push_frame(input logic [7:0] b);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) for (int r = 0; r < TPB; r++) q.push_back(bits[i]);
    endfunction

    always @(posedge i_clk) begin : model
        logic popped, hv_old, xfer;
        cyc <= cyc + 1;
        if (i_rst) begin
            q.delete();
            m_hold_v = 1'b0;
            e_serial = 1'b1;
            e_ready  = 1'b1;
            e_active = 1'b0;
            e_done   = 1'b0;
            model_on = 1'b1;
        end else if (model_on) begin
            xfer   = i_tx_dv && e_ready;
            popped = (q.size() > 0);
            if (popped) void'(q.pop_front());
            e_done = popped && (q.size() == 0);
            hv_old = m_hold_v;
            if (q.size() == 0 && m_hold_v) begin
                push_frame(m_hold_b);
                m_hold_v = 1'b0;
            end
            if (xfer) begin
                m_hold_v = 1'b1;
                m_hold_b = i_tx_byte;
            end
            e_ready  = !(m_hold_v || hv_old);
            e_active = (q.size() > 0);
            e_serial = (q.size() > 0) ? q[0] : 1'b1;
        end
    end

    always @(negedge i_clk) begin
        if (cyc < LOGN) begin
            log_ser[cyc]  = o_tx_serial;
            log_done[cyc] = o_tx_done;
            log_rdy[cyc]  = o_tx_ready;
        end
        if (model_on) begin
            check("serial", 32'(o_tx_serial), 32'(e_serial));
            check("ready",  32'(o_tx_ready),  32'(e_ready));
            check("active", 32'(o_tx_active), 32'(e_active));
            check("done",   32'(o_tx_done),   32'(e_done));
        end
    end

    task automatic send(input logic [7:0] b, output int t);
        int n = 0;
        while (!o_tx_ready && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        check("ready_before_send", 32'(o_tx_ready), 32'd1);
        i_tx_dv   = 1'b1;
        i_tx_byte = b;
        t = cyc;
        @(negedge i_clk);
        i_tx_dv   = 1'b0;
        i_tx_byte = 8'hEE;
    endtask

    // pat: start bit, 8 data bits LSB first, then stop bit (parity bit checked separately)
    task automatic chk_frame(input string name, input int t, input logic [0:9] pat);
        for (int k = 0; k < 9; k++)
            check($sformatf("%s_bit%0d", name, k), 32'(log_ser[t + 2 + k * TPB + 1]), 32'(pat[k]));
        check({name, "_stop"}, 32'(log_ser[t + 2 + (FB - 1) * TPB + 1]), 32'(pat[9]));
        check({name, "_done"}, 32'(log_done[t + 2 + FL]), 32'd1);
    endtask

    function automatic int count_done(input int a, input int b);
        int c = 0;
        for (int i = a; i <= b; i++) if (log_done[i] === 1'b1) c++;
        return c;
    endfunction

    initial begin
        int t, t1, t2;
        i_rst = 1'b1;
        i_tx_dv = 1'b0;
        i_tx_byte = 8'h00;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (50) @(negedge i_clk);
        check("idle_serial", 32'(o_tx_serial), 32'd1);
        check("idle_ready",  32'(o_tx_ready),  32'd1);
        check("idle_active", 32'(o_tx_active), 32'd0);
        check("idle_done_cnt", 32'(count_done(3, cyc)), 32'd0);

        // Single byte 0xA5
        send(8'hA5, t);
        repeat (FL + 6) @(negedge i_clk);
        chk_frame("a5", t, 10'b0101001011);
        check("a5_first_start", 32'(log_ser[t + 2]), 32'd0);
        check("a5_pre_start",   32'(log_ser[t + 1]), 32'd1);
        check("a5_rdy_t1", 32'(log_rdy[t + 1]), 32'd0);
        check("a5_rdy_t2", 32'(log_rdy[t + 2]), 32'd0);
        check("a5_rdy_t3", 32'(log_rdy[t + 3]), 32'd1);
        check("a5_done_cnt", 32'(count_done(t, t + FL + 5)), 32'd1);

        // Back-to-back 0x00 then 0xFF
        send(8'h00, t1);
        send(8'hFF, t2);
        repeat (2 * FL + 8) @(negedge i_clk);
        chk_frame("b2b_00", t1, 10'b0000000001);
        chk_frame("b2b_ff", t1 + FL, 10'b0111111111);
        check("b2b_last_stop", 32'(log_ser[t1 + 1 + FL]), 32'd1);
        check("b2b_next_start", 32'(log_ser[t1 + 2 + FL]), 32'd0);
        check("b2b_done_cnt", 32'(count_done(t1, t1 + 2 * FL + 6)), 32'd2);

        // 0x3C offered while the holding register is full
        send(8'h5A, t1);
        send(8'hC3, t2);
        i_tx_dv = 1'b1;
        i_tx_byte = 8'h3C;
        repeat (4) @(negedge i_clk);
        i_tx_dv = 1'b0;
        repeat (2 * FL + 10) @(negedge i_clk);
        chk_frame("full_5a", t1, 10'b0010110101);
        chk_frame("full_c3", t1 + FL, 10'b0110000111);
        check("full_no_third", 32'(log_ser[t1 + 2 + 2 * FL + 2]), 32'd1);
        check("full_done_cnt", 32'(count_done(t1, t1 + 2 * FL + 8)), 32'd2);

        // Reset during data bit 3 of 0x55
        send(8'h55, t);
        repeat (18) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (50) @(negedge i_clk);
        check("rst_bit3", 32'(log_ser[t + 18]), 32'd0);
        check("rst_line_high", 32'(log_ser[t + 20]), 32'd1);
        check("rst_ready", 32'(log_rdy[t + 20]), 32'd1);
        check("rst_no_done", 32'(count_done(t, t + 69)), 32'd0);
        send(8'h81, t);
        repeat (FL + 6) @(negedge i_clk);
        chk_frame("after_rst_81", t, 10'b0100000011);

`ifdef UART_TX_PARITY_EN
        send(8'h07, t1);
        send(8'h03, t2);
        repeat (2 * FL + 8) @(negedge i_clk);
        check("par_07", 32'(log_ser[t1 + 2 + 9 * TPB + 1]), 32'd1);
        check("par_03", 32'(log_ser[t1 + FL + 2 + 9 * TPB + 1]), 32'd0);
        check("par_done1", 32'(log_done[t1 + 2 + 44]), 32'd1);
        check("par_done2", 32'(log_done[t1 + 2 + 88]), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
